// File: rtl/reg_bus_arb.sv
// reg_bus_arb: arbitrates two requesters onto a single-outstanding register bus.
// Each accepted transaction runs IDLE -> ISSUE (one-cycle bus strobe), then
// returns to IDLE for a write or passes through CAPT for a read.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/rw/addr/wdata      requester N transaction, held until ready
//   reqN_ready                    combinational acceptance strobe (IDLE only)
//   reqN_done                     one-cycle completion pulse to requester N
//   reqN_rdata                    last read data returned to requester N
//   valid/rw/addr_to_reg/data_to_reg  register-bus request
//   data_in_reg                   register-bus read data, valid the cycle after the strobe
//   busy                          high whenever the FSM is not in IDLE
module reg_bus_arb #(
  parameter bit PRIO_FIX = 1'b0,
  localparam int unsigned AW = 4,
  localparam int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_rw,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  input  logic          req1_rw,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          req0_done,
  output logic          req1_done,
  output logic [DW-1:0] req0_rdata,
  output logic [DW-1:0] req1_rdata,
  output logic          valid,
  output logic          rw,
  output logic [AW-1:0] addr_to_reg,
  output logic [DW-1:0] data_to_reg,
  input  logic [DW-1:0] data_in_reg,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_e;

  state_e        state_q, state_d;
  logic          owner_q;
  logic          last_q;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          pick1;
  logic          accept;
  logic          ready0, ready1;
  logic          capt_en;

  // Winner selection: fixed priority favours req0; round-robin favours the
  // requester that did not win last time when both are pending.
  always_comb begin
    if (PRIO_FIX) pick1 = req1_valid & ~req0_valid;
    else          pick1 = req1_valid & (~req0_valid | ~last_q);
  end

  // Next-state, acceptance and completion decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ready0  = 1'b0;
    ready1  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    capt_en = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps ready low while reset is held
        if ((req0_valid | req1_valid) && rst_n) begin
          accept  = 1'b1;
          ready0  = ~pick1;
          ready1  = pick1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (rw_q) begin
          state_d = IDLE;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        state_d = IDLE;
        capt_en = 1'b1;
        done0_d = ~owner_q;
        done1_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  // Captured transaction; these registers also drive the bus, so the bus
  // fields hold their last values outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner_q <= pick1;
      last_q  <= pick1;
      rw_q    <= pick1 ? req1_rw    : req0_rw;
      addr_q  <= pick1 ? req1_addr  : req0_addr;
      wdata_q <= pick1 ? req1_wdata : req0_wdata;
    end
  end

  // Read data returns only to the owning requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (capt_en) begin
      if (owner_q) rdata1_q <= data_in_reg;
      else         rdata0_q <= data_in_reg;
    end
  end

  assign req0_ready  = ready0;
  assign req1_ready  = ready1;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign valid       = (state_q == ISSUE);
  assign rw          = rw_q;
  assign addr_to_reg = addr_q;
  assign data_to_reg = wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bus_arb.sv
// Testbench for reg_bus_arb: directed scenarios followed by random traffic,
// all checked cycle-by-cycle against a transaction-level reference model.
// A second instance with fixed priority runs with both requesters always valid.
module tb_reg_bus_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_rw, req1_valid, req1_rw;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready, req0_done, req1_done;
  logic [7:0] req0_rdata, req1_rdata;
  logic       valid, rw, busy;
  logic [3:0] addr_to_reg;
  logic [7:0] data_to_reg, data_in_reg;

  logic       f_r0_ready, f_r1_ready, f_r0_done, f_r1_done;
  logic [7:0] f_r0_rdata, f_r1_rdata, f_data_to_reg;
  logic       f_valid, f_rw, f_busy;
  logic [3:0] f_addr_to_reg;

  always #5 clk = ~clk;

  reg_bus_arb #(.PRIO_FIX(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
    .valid(valid), .rw(rw), .addr_to_reg(addr_to_reg), .data_to_reg(data_to_reg),
    .data_in_reg(data_in_reg), .busy(busy)
  );

  // Fixed-priority instance: both requesters always pending writes.
  reg_bus_arb #(.PRIO_FIX(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(1'b1), .req0_rw(1'b1), .req0_addr(4'h1), .req0_wdata(8'h11),
    .req1_valid(1'b1), .req1_rw(1'b1), .req1_addr(4'h2), .req1_wdata(8'h22),
    .req0_ready(f_r0_ready), .req1_ready(f_r1_ready),
    .req0_done(f_r0_done), .req1_done(f_r1_done),
    .req0_rdata(f_r0_rdata), .req1_rdata(f_r1_rdata),
    .valid(f_valid), .rw(f_rw), .addr_to_reg(f_addr_to_reg), .data_to_reg(f_data_to_reg),
    .data_in_reg(8'h00), .busy(f_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester side
  bit         pend [2];
  bit         p_rw [2];
  logic [3:0] p_addr [2];
  logic [7:0] p_wd [2];

  // reference model: one transaction in flight at most
  logic [7:0] mem [16];
  bit         inflight;
  int         t_acc;
  bit         m_owner, m_rw, m_last;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, rval;
  logic [7:0] m_rd0, m_rd1;
  bit         bus_rw;
  logic [3:0] bus_addr;
  logic [7:0] bus_data;

  // snapshots taken at the negedge of the last cycle
  logic s_rdy0, s_rdy1, s_d0, s_d1, s_valid, s_rw, s_busy;
  logic [3:0] s_addr;
  logic [7:0] s_data, s_rd0, s_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_txn(input int r, input bit wr);
    pend[r]   = 1'b1;
    p_rw[r]   = wr;
    p_addr[r] = 4'($urandom);
    p_wd[r]   = 8'($urandom);
  endtask

  task automatic model_reset();
    inflight = 1'b0;
    m_last   = 1'b1;
    m_rd0    = 8'h00;
    m_rd1    = 8'h00;
    bus_rw   = 1'b0;
    bus_addr = 4'h0;
    bus_data = 8'h00;
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
  endtask

  task automatic do_reset();
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_rw", 32'(rw), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready0", 32'(req0_ready), 32'(0));
    chk("rst_ready1", 32'(req1_ready), 32'(0));
    chk("rst_done0", 32'(req0_done), 32'(0));
    chk("rst_done1", 32'(req1_done), 32'(0));
    chk("rst_addr", 32'(addr_to_reg), 32'(0));
    chk("rst_data", 32'(data_to_reg), 32'(0));
    chk("rst_rdata0", 32'(req0_rdata), 32'(0));
    chk("rst_rdata1", 32'(req1_rdata), 32'(0));
    chk("rst_fix_ready0", 32'(f_r0_ready), 32'(0));
    chk("rst_fix_valid", 32'(f_valid), 32'(0));
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, advance the model, compare at negedge.
  task automatic cycle();
    bit e_r0, e_r1, e_valid, e_d0, e_d1, e_busy;
    data_in_reg = (inflight && !m_rw && cyc == t_acc + 2) ? rval : 8'($urandom);
    req0_valid = pend[0]; req0_rw = p_rw[0]; req0_addr = p_addr[0]; req0_wdata = p_wd[0];
    req1_valid = pend[1]; req1_rw = p_rw[1]; req1_addr = p_addr[1]; req1_wdata = p_wd[1];

    e_r0 = 1'b0; e_r1 = 1'b0; e_valid = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    if (inflight) begin
      if (cyc == t_acc + 1) begin
        e_valid  = 1'b1;
        bus_rw   = m_rw;
        bus_addr = m_addr;
        bus_data = m_wdata;
        if (m_rw) mem[m_addr] = m_wdata;
        else      rval = mem[m_addr];
      end
      if (cyc == t_acc + (m_rw ? 2 : 3)) begin
        if (m_owner) e_d1 = 1'b1; else e_d0 = 1'b1;
        if (!m_rw) begin
          if (m_owner) m_rd1 = rval; else m_rd0 = rval;
        end
        inflight = 1'b0;
      end
    end
    e_busy = inflight;
    if (!inflight && (pend[0] || pend[1])) begin
      m_owner  = (pend[0] && pend[1]) ? !m_last : pend[1];
      m_last   = m_owner;
      m_rw     = p_rw[m_owner];
      m_addr   = p_addr[m_owner];
      m_wdata  = p_wd[m_owner];
      inflight = 1'b1;
      t_acc    = cyc;
      if (m_owner) e_r1 = 1'b1; else e_r0 = 1'b1;
      pend[m_owner] = 1'b0;
    end

    @(negedge clk);
    s_rdy0 = req0_ready; s_rdy1 = req1_ready; s_d0 = req0_done; s_d1 = req1_done;
    s_valid = valid; s_rw = rw; s_busy = busy; s_addr = addr_to_reg; s_data = data_to_reg;
    s_rd0 = req0_rdata; s_rd1 = req1_rdata;
    chk("ready0", 32'(s_rdy0), 32'(e_r0));
    chk("ready1", 32'(s_rdy1), 32'(e_r1));
    chk("valid", 32'(s_valid), 32'(e_valid));
    chk("busy", 32'(s_busy), 32'(e_busy));
    chk("done0", 32'(s_d0), 32'(e_d0));
    chk("done1", 32'(s_d1), 32'(e_d1));
    chk("bus_rw", 32'(s_rw), 32'(bus_rw));
    chk("bus_addr", 32'(s_addr), 32'(bus_addr));
    chk("bus_data", 32'(s_data), 32'(bus_data));
    chk("rdata0", 32'(s_rd0), 32'(m_rd0));
    chk("rdata1", 32'(s_rd1), 32'(m_rd1));
    chk("fix_ready1", 32'(f_r1_ready), 32'(0));
    if (f_valid) chk("fix_addr", 32'(f_addr_to_reg), 32'(4'h1));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int g_cnt;
    int f_cnt;
    int last_acc;
    logic [7:0] exp6;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
    data_in_reg = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[9] = 8'h5C;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // single write from req0
    pend[0] = 1'b1; p_rw[0] = 1'b1; p_addr[0] = 4'h3; p_wd[0] = 8'hA5;
    cycle();
    chk("wr_t0_ready0", 32'(s_rdy0), 32'(1));
    chk("wr_t0_valid", 32'(s_valid), 32'(0));
    cycle();
    chk("wr_t1_valid", 32'(s_valid), 32'(1));
    chk("wr_t1_rw", 32'(s_rw), 32'(1));
    chk("wr_t1_addr", 32'(s_addr), 32'(4'h3));
    chk("wr_t1_data", 32'(s_data), 32'(8'hA5));
    cycle();
    chk("wr_t2_done0", 32'(s_d0), 32'(1));
    chk("wr_t2_valid", 32'(s_valid), 32'(0));

    // single read from req1
    pend[1] = 1'b1; p_rw[1] = 1'b0; p_addr[1] = 4'h9; p_wd[1] = 8'h00;
    cycle();
    chk("rd_t0_ready1", 32'(s_rdy1), 32'(1));
    cycle();
    chk("rd_t1_valid", 32'(s_valid), 32'(1));
    chk("rd_t1_rw", 32'(s_rw), 32'(0));
    cycle();
    chk("rd_t2_done1", 32'(s_d1), 32'(0));
    cycle();
    chk("rd_t3_done1", 32'(s_d1), 32'(1));
    chk("rd_t3_rdata1", 32'(s_rd1), 32'(8'h5C));
    chk("rd_t3_rdata0", 32'(s_rd0), 32'(0));

    // round-robin contention from reset, both continuously writing
    do_reset();
    g_cnt = 0; f_cnt = 0; last_acc = -2;
    for (int k = 0; k < 12; k++) begin
      if (!pend[0]) new_txn(0, 1'b1);
      if (!pend[1]) new_txn(1, 1'b1);
      cycle();
      if (f_r0_ready) f_cnt++;
      if (s_rdy0 || s_rdy1) begin
        chk("rr_order", 32'(s_rdy1), 32'(g_cnt % 2));
        chk("rr_spacing", 32'(k - last_acc), 32'(2));
        chk("rr_overlap", 32'(s_rdy0 & s_rdy1), 32'(0));
        last_acc = k;
        g_cnt++;
      end
    end
    chk("rr_grants", 32'(g_cnt), 32'(6));
    chk("fix_grants0", 32'(f_cnt), 32'(6));

    // drain, then back-to-back: done0 coincides with ready1
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (3) cycle();
    new_txn(0, 1'b1);
    cycle();
    chk("b2b_t0_ready0", 32'(s_rdy0), 32'(1));
    new_txn(1, 1'b1);
    cycle();
    cycle();
    chk("b2b_t2_done0", 32'(s_d0), 32'(1));
    chk("b2b_t2_ready1", 32'(s_rdy1), 32'(1));
    cycle();
    chk("b2b_t3_valid", 32'(s_valid), 32'(1));
    chk("b2b_t3_addr", 32'(s_addr), 32'(p_addr[1]));

    // reset in CAPT aborts the read, then a fresh read completes
    cycle();
    pend[0] = 1'b1; p_rw[0] = 1'b0; p_addr[0] = 4'h5; p_wd[0] = 8'h00;
    cycle();
    cycle();
    do_reset();
    cycle();
    chk("abort_done0", 32'(s_d0), 32'(0));
    exp6 = mem[6];
    pend[0] = 1'b1; p_rw[0] = 1'b0; p_addr[0] = 4'h6; p_wd[0] = 8'h00;
    repeat (4) cycle();
    chk("rerd_done0", 32'(s_d0), 32'(1));
    chk("rerd_rdata0", 32'(s_rd0), 32'(exp6));

    // random traffic, including withdrawn requests
    for (int k = 0; k < 600; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 2) == 0) new_txn(r, 1'($urandom));
        end else if ($urandom_range(0, 9) == 0) begin
          pend[r] = 1'b0;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_arb.md
REG_BUS_ARB -- requirements
Module: reg_bus_arb

Interface
REQ-001 Parameter: PRIO_FIX, default 0, meaning 0 = round-robin arbitration, 1 = fixed priority to requester 0.
REQ-002 Port: clk  input  1  single block clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: req0_valid / req1_valid  input  1  requester N has a pending transaction; held until accepted.
REQ-005 Port: req0_rw / req1_rw  input  1  1 = write, 0 = read.
REQ-006 Port: req0_addr / req1_addr  input  4  register address.
REQ-007 Port: req0_wdata / req1_wdata  input  8  write data.
REQ-008 Port: req0_ready / req1_ready  output  1  acceptance strobe; request is captured in this cycle.
REQ-009 Port: req0_done / req1_done  output  1  one-cycle completion pulse.
REQ-010 Port: req0_rdata / req1_rdata  output  8  last read data for requester N; held until its next read completes.
REQ-011 Port: valid  output  1  register-bus strobe to the register block.
REQ-012 Port: rw  output  1  register-bus direction; 1 = write.
REQ-013 Port: addr_to_reg  output  4  register-bus address.
REQ-014 Port: data_to_reg  output  8  register-bus write data.
REQ-015 Port: data_in_reg  input  8  register-bus read data; valid the cycle after valid=1 with rw=0.
REQ-016 Port: busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and CAPT.
REQ-018 IDLE: if any reqN_valid is high, the block SHALL select one requester, assert only that reqN_ready combinationally, capture rw/addr/wdata and the owner ID into registers, and move to ISSUE.
REQ-019 IDLE with no request: outputs SHALL stay idle (valid=0), and the state SHALL remain IDLE.
REQ-020 ISSUE: valid=1 for exactly one cycle, with rw/addr_to_reg/data_to_reg driven from the captured registers.
REQ-021 ISSUE to IDLE for a write; ISSUE to CAPT for a read.
REQ-022 CAPT: the block SHALL register data_in_reg into the owner's reqN_rdata and return to IDLE.
REQ-023 The owner's reqN_done SHALL pulse in the cycle after ISSUE for a write, and in the cycle after CAPT for a read.
REQ-024 Throughput SHALL be one write every 2 cycles and one read every 3 cycles, because done and the next accept may coincide in IDLE.
REQ-025 Round-robin (PRIO_FIX=0): when both requests are valid, the grant SHALL go to the requester not granted last; a single valid requester SHALL always be granted.
REQ-026 The last-grant register SHALL update only on acceptance.
REQ-027 Fixed priority (PRIO_FIX=1): req0 SHALL win whenever req0_valid=1.
REQ-028 Outside the ISSUE state, valid SHALL be 0, and rw/addr_to_reg/data_to_reg SHALL hold their last values.
REQ-029 reqN_ready SHALL be 0 in every state except IDLE, and at most one ready SHALL be high per cycle.
REQ-030 A requester dropping reqN_valid before ready SHALL cause no transaction.
REQ-031 Reads SHALL never modify the rdata of the non-owning requester.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE; valid, rw, busy, all ready and all done = 0; addr_to_reg=0; data_to_reg=0; req0_rdata=req1_rdata=0; last-grant = requester 1, so requester 0 wins the first tie.
REQ-033 Reset during ISSUE or CAPT SHALL abort the transaction with no done pulse and no rdata update; after release, operation SHALL restart from IDLE.

Verification
REQ-034 Single write: req0 write addr=0x3 wdata=0xA5 -> ready0 at T0; valid=1, rw=1, addr=0x3, data=0xA5 at T1; done0 at T2; valid=0 otherwise.
REQ-035 Single read: req1 read addr=0x9, and the model returns 0x5C the cycle after valid -> valid=1, rw=0 at T1; req1_rdata=0x5C and done1 at T3; req0_rdata unchanged.
REQ-036 Contention, PRIO_FIX=0: both requesters continuously issue writes from reset -> grant order 0,1,0,1, one strobe every 2 cycles, no ready overlap.
REQ-037 Contention, PRIO_FIX=1: both requesters continuously valid -> req0 is always granted and req1 starves while req0 stays valid.
REQ-038 Reset mid-read: assert rst_n=0 during CAPT -> all outputs 0 immediately, no done; after release, a new req0 read completes normally.
REQ-039 Back-to-back: done0 of a write and ready1 occur in the same cycle -> the next valid follows one cycle later; the bus shows no gap beyond 1 cycle.
